// File: rtl/mips_cpu_mult_div.sv
// Iterative 32-bit multiply/divide unit holding the architectural HI/LO registers.
// Services MULT/MULTU/DIV/DIVU in 33 clocks and MTHI/MTLO in one.
module mips_cpu_mult_div (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [5:0]  funct,
  input  logic [31:0] rs_content,
  input  logic [31:0] rt_content,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam int unsigned W     = 32;
  localparam int unsigned CNT_W = 6;

  localparam logic [5:0] F_MTHI  = 6'h11;
  localparam logic [5:0] F_MTLO  = 6'h13;
  localparam logic [5:0] F_MULT  = 6'h18;
  localparam logic [5:0] F_MULTU = 6'h19;
  localparam logic [5:0] F_DIV   = 6'h1A;
  localparam logic [5:0] F_DIVU  = 6'h1B;

  localparam logic [CNT_W-1:0] ITER_LAST = CNT_W'(W - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIXUP} state_t;

  state_t state, state_nxt;

  logic [CNT_W-1:0] cnt, cnt_d;
  logic             op_mul, op_mul_d;
  logic             op_signed, op_signed_d;
  logic [W-1:0]     a_raw, a_raw_d;
  logic [W-1:0]     b_raw, b_raw_d;
  logic [W-1:0]     m, m_d;
  logic [2*W-1:0]   acc, acc_d;
  logic [W-1:0]     hi_d, lo_d;
  logic             busy_d, done_d;

  // Operand decode and magnitudes
  logic         is_mul, is_div, is_signed;
  logic [W-1:0] rs_mag, rt_mag;

  assign is_mul    = (funct == F_MULT) || (funct == F_MULTU);
  assign is_div    = (funct == F_DIV)  || (funct == F_DIVU);
  assign is_signed = (funct == F_MULT) || (funct == F_DIV);
  assign rs_mag    = (is_signed && rs_content[W-1]) ? W'(-rs_content) : rs_content;
  assign rt_mag    = (is_signed && rt_content[W-1]) ? W'(-rt_content) : rt_content;

  // One shift-add multiply step and one restoring divide step on acc
  logic [W:0]     add_sum, rem_sh, rem_diff;
  logic           q_bit;
  logic [2*W-1:0] mul_step, div_step;

  assign add_sum  = {1'b0, acc[2*W-1:W]} + {1'b0, (acc[0] ? m : W'(0))};
  assign mul_step = {add_sum, acc[W-1:1]};
  assign rem_sh   = {acc[2*W-1:W], acc[W-1]};
  assign rem_diff = rem_sh - {1'b0, m};
  assign q_bit    = (rem_sh >= {1'b0, m});
  assign div_step = q_bit ? {rem_diff[W-1:0], acc[W-2:0], 1'b1}
                          : {rem_sh[W-1:0],   acc[W-2:0], 1'b0};

  // Sign correction applied in FIXUP
  logic           neg_res, neg_rem;
  logic [2*W-1:0] prod_fix;
  logic [W-1:0]   quo_fix, rem_fix;

  assign neg_res  = op_signed && (a_raw[W-1] ^ b_raw[W-1]);
  assign neg_rem  = op_signed && a_raw[W-1];
  assign prod_fix = neg_res ? (2*W)'(-acc) : acc;
  assign quo_fix  = neg_res ? W'(-acc[W-1:0]) : acc[W-1:0];
  assign rem_fix  = neg_rem ? W'(-acc[2*W-1:W]) : acc[2*W-1:W];

  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start && (is_mul || is_div)) state_nxt = S_RUN;
      S_RUN:   if (cnt == ITER_LAST) state_nxt = S_FIXUP;
      S_FIXUP: state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    cnt_d       = cnt;
    op_mul_d    = op_mul;
    op_signed_d = op_signed;
    a_raw_d     = a_raw;
    b_raw_d     = b_raw;
    m_d         = m;
    acc_d       = acc;
    hi_d        = hi;
    lo_d        = lo;
    done_d      = 1'b0;
    busy_d      = (state_nxt != S_IDLE);
    case (state)
      S_IDLE: begin
        if (start && (is_mul || is_div)) begin
          cnt_d       = '0;
          op_mul_d    = is_mul;
          op_signed_d = is_signed;
          a_raw_d     = rs_content;
          b_raw_d     = rt_content;
          m_d         = is_mul ? rs_mag : rt_mag;
          acc_d       = {W'(0), (is_mul ? rt_mag : rs_mag)};
        end else if (start && (funct == F_MTHI)) begin
          hi_d   = rs_content;
          done_d = 1'b1;
        end else if (start && (funct == F_MTLO)) begin
          lo_d   = rs_content;
          done_d = 1'b1;
        end
      end
      S_RUN: begin
        acc_d = op_mul ? mul_step : div_step;
        cnt_d = CNT_W'(cnt + 1'b1);
      end
      S_FIXUP: begin
        done_d = 1'b1;
        if (op_mul) begin
          hi_d = prod_fix[2*W-1:W];
          lo_d = prod_fix[W-1:0];
        end else if (b_raw == '0) begin
          // Divide by zero returns the dividend in HI and all ones in LO
          hi_d = a_raw;
          lo_d = '1;
        end else begin
          hi_d = rem_fix;
          lo_d = quo_fix;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt       <= '0;
      op_mul    <= 1'b0;
      op_signed <= 1'b0;
      a_raw     <= '0;
      b_raw     <= '0;
      m         <= '0;
      acc       <= '0;
      hi        <= '0;
      lo        <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      cnt       <= cnt_d;
      op_mul    <= op_mul_d;
      op_signed <= op_signed_d;
      a_raw     <= a_raw_d;
      b_raw     <= b_raw_d;
      m         <= m_d;
      acc       <= acc_d;
      hi        <= hi_d;
      lo        <= lo_d;
      busy      <= busy_d;
      done      <= done_d;
    end
  end

endmodule

// File: tb/tb_mips_cpu_mult_div.sv
// Directed self-checking bench for mips_cpu_mult_div with hand-computed results.
module tb_mips_cpu_mult_div;

  logic        clk = 1'b0;
  logic        reset, start;
  logic [5:0]  funct;
  logic [31:0] rs_content, rt_content;
  logic        busy, done;
  logic [31:0] hi, lo;

  int checks = 0;
  int errors = 0;

  localparam logic [5:0] F_MTHI  = 6'h11;
  localparam logic [5:0] F_MTLO  = 6'h13;
  localparam logic [5:0] F_MULT  = 6'h18;
  localparam logic [5:0] F_MULTU = 6'h19;
  localparam logic [5:0] F_DIV   = 6'h1A;
  localparam logic [5:0] F_DIVU  = 6'h1B;

  mips_cpu_mult_div dut (
    .clk(clk), .reset(reset), .start(start), .funct(funct),
    .rs_content(rs_content), .rt_content(rt_content),
    .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Advance one clock and settle just after the edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
    start = 1'b1; funct = f; rs_content = a; rt_content = b;
    step();
    start = 1'b0; funct = 6'h00;
  endtask

  // Wait (bounded) for done and check latency and results; leaves sim in the done cycle
  task automatic wait_result(input string tag, input int exp_lat,
                             input logic [31:0] eh, input logic [31:0] el);
    int n = 0;
    while (done !== 1'b1 && n < 60) begin
      step();
      n++;
    end
    check({tag, "_lat"}, 64'(n), 64'(exp_lat));
    check({tag, "_hi"}, {32'h0, hi}, {32'h0, eh});
    check({tag, "_lo"}, {32'h0, lo}, {32'h0, el});
    check({tag, "_busy_end"}, {63'h0, busy}, 64'h0);
  endtask

  task automatic run_op(input string tag, input logic [5:0] f, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] eh, input logic [31:0] el);
    issue(f, a, b);
    check({tag, "_busy"}, {63'h0, busy}, 64'h1);
    wait_result(tag, 33, eh, el);
    step();
    check({tag, "_done_drop"}, {63'h0, done}, 64'h0);
  endtask

  initial begin
    int pulses;
    reset = 1'b1; start = 1'b0; funct = '0; rs_content = '0; rt_content = '0;
    step(); step();
    reset = 1'b0;
    check("rst_hi",   {32'h0, hi}, 64'h0);
    check("rst_lo",   {32'h0, lo}, 64'h0);
    check("rst_busy", {63'h0, busy}, 64'h0);
    check("rst_done", {63'h0, done}, 64'h0);

    run_op("multu_max", F_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001);
    run_op("mult_neg",  F_MULT,  32'hFFFFFFFD, 32'd7,        32'hFFFFFFFF, 32'hFFFFFFEB);
    run_op("mult_min",  F_MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000);
    run_op("divu",      F_DIVU,  32'd100,      32'd7,        32'h00000002, 32'h0000000E);
    run_op("div_neg",   F_DIV,   32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD);
    run_op("div_zero",  F_DIV,   32'd5,        32'd0,        32'h00000005, 32'hFFFFFFFF);
    run_op("divu_zero", F_DIVU,  32'hFFFFFFF0, 32'd0,        32'hFFFFFFF0, 32'hFFFFFFFF);
    run_op("div_ovf",   F_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000);

    // MTHI then MTLO on consecutive cycles
    start = 1'b1; funct = F_MTHI; rs_content = 32'h12345678;
    step();
    check("mthi_hi",   {32'h0, hi}, 64'h12345678);
    check("mthi_lo",   {32'h0, lo}, 64'h80000000);
    check("mthi_done", {63'h0, done}, 64'h1);
    check("mthi_busy", {63'h0, busy}, 64'h0);
    funct = F_MTLO; rs_content = 32'h9ABCDEF0;
    step();
    start = 1'b0; funct = 6'h00;
    check("mtlo_lo",   {32'h0, lo}, 64'h9ABCDEF0);
    check("mtlo_hi",   {32'h0, hi}, 64'h12345678);
    check("mtlo_done", {63'h0, done}, 64'h1);
    check("mtlo_busy", {63'h0, busy}, 64'h0);
    step();
    check("mt_done_drop", {63'h0, done}, 64'h0);

    // Unknown funct is ignored
    issue(6'h20, 32'hDEADBEEF, 32'h1);
    check("bad_done", {63'h0, done}, 64'h0);
    check("bad_busy", {63'h0, busy}, 64'h0);
    check("bad_hi",   {32'h0, hi}, 64'h12345678);
    check("bad_lo",   {32'h0, lo}, 64'h9ABCDEF0);

    // start while busy is ignored; start in the done cycle is accepted
    issue(F_MULTU, 32'd3, 32'd5);
    repeat (9) step();
    check("busy_hi_hold", {32'h0, hi}, 64'h12345678);
    start = 1'b1; funct = F_DIVU; rs_content = 32'd100; rt_content = 32'd7;
    step();
    start = 1'b0; funct = 6'h00;
    wait_result("mul_ign", 23, 32'h0, 32'd15);
    start = 1'b1; funct = F_MULTU; rs_content = 32'd2; rt_content = 32'd9;
    step();
    start = 1'b0; funct = 6'h00;
    check("b2b_busy", {63'h0, busy}, 64'h1);
    wait_result("b2b", 33, 32'h0, 32'd18);
    step();

    // Reset in the middle of a DIV discards it
    issue(F_DIV, 32'd1000, 32'd3);
    repeat (14) step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("mid_rst_hi",   {32'h0, hi}, 64'h0);
    check("mid_rst_lo",   {32'h0, lo}, 64'h0);
    check("mid_rst_busy", {63'h0, busy}, 64'h0);
    pulses = 0;
    for (int i = 0; i < 25; i++) begin
      if (done === 1'b1) pulses++;
      step();
    end
    check("mid_rst_nodone", 64'(pulses), 64'h0);
    run_op("post_rst", F_MULTU, 32'd6, 32'd7, 32'h0, 32'd42);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
